// File: rtl/stream_mux_pkg.sv
// Shared definitions for the symbol-stream mux/demux pair: FSM states, mode codes, sync word.
package stream_mux_pkg;

  typedef enum logic [1:0] {StIdle, StPass, StHunt, StLocked} state_e;

  localparam logic [2:0] MODE_IDLE = 3'd0;
  localparam logic [2:0] MODE_PASS = 3'd1;
  localparam logic [2:0] MODE_ALT2 = 3'd2;
  localparam logic [2:0] MODE_ROT3 = 3'd3;

  localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hA5A5_5A5A;

  function automatic logic [1:0] nslots_for(input logic [2:0] mode);
    return (mode == MODE_ROT3) ? 2'd3 : 2'd2;
  endfunction

endpackage

// File: rtl/slot_tracker.sv
// Tracks position inside a frame: symbol count within the slot, slot index and
// whether the next word must be a sync word.
module slot_tracker #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             symbol_clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  input  logic [CNT_W-1:0] switch_symbols,
  input  logic [1:0]       nslots,
  output logic [1:0]       slot,
  output logic             expect_sync
);
  import stream_mux_pkg::*;

  logic [CNT_W-1:0] slot_len_q, slot_len_d;
  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [1:0]       nslots_q, nslots_d;
  logic [1:0]       slot_q, slot_d;
  logic             expect_q, expect_d;

  always_comb begin
    slot_len_d = slot_len_q;
    sym_cnt_d  = sym_cnt_q;
    nslots_d   = nslots_q;
    slot_d     = slot_q;
    expect_d   = expect_q;
    if (load) begin
      // A zero slot length would make the counter compare wrap; treat it as one.
      slot_len_d = (switch_symbols == '0) ? CNT_W'(1) : switch_symbols;
      nslots_d   = nslots;
      sym_cnt_d  = '0;
      slot_d     = '0;
      expect_d   = 1'b0;
    end else if (advance) begin
      if (sym_cnt_q == slot_len_q - CNT_W'(1)) begin
        sym_cnt_d = '0;
        if (slot_q == nslots_q - 2'd1) begin
          slot_d   = '0;
          expect_d = 1'b1;
        end else begin
          slot_d = slot_q + 2'd1;
        end
      end else begin
        sym_cnt_d = sym_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge symbol_clk) begin
    if (rst) begin
      slot_len_q <= CNT_W'(1);
      sym_cnt_q  <= '0;
      nslots_q   <= 2'd2;
      slot_q     <= '0;
      expect_q   <= 1'b0;
    end else begin
      slot_len_q <= slot_len_d;
      sym_cnt_q  <= sym_cnt_d;
      nslots_q   <= nslots_d;
      slot_q     <= slot_d;
      expect_q   <= expect_d;
    end
  end

  assign slot        = slot_q;
  assign expect_sync = expect_q;

endmodule

// File: rtl/stream_demux_deframer.sv
// Splits the time-multiplexed symbol stream into three per-stream outputs, hunting for
// and tracking frame sync, and counting lock losses.
module stream_demux_deframer
  import stream_mux_pkg::*;
#(
  parameter logic [31:0] SYNC_WORD = SYNC_WORD_DEFAULT,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             symbol_clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] switch_symbols,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic [31:0]      ds1_data,
  output logic [31:0]      ds2_data,
  output logic [31:0]      ds3_data,
  output logic             ds1_valid,
  output logic             ds2_valid,
  output logic             ds3_valid,
  output logic             locked,
  output logic             sync_err,
  output logic [7:0]       err_count
);

  state_e      state_q, state_d;
  logic [2:0]  mode_q;
  logic [31:0] ds1_data_q, ds2_data_q, ds3_data_q;
  logic        ds1_valid_q, ds2_valid_q, ds3_valid_q;
  logic        sync_err_q, sync_err_d;
  logic [7:0]  err_count_q;

  logic        load, advance, expect_sync, is_sync;
  logic [1:0]  slot;
  logic [2:0]  route;

  assign is_sync = (in_data == SYNC_WORD);

  slot_tracker #(
    .CNT_W (CNT_W)
  ) u_slot_tracker (
    .symbol_clk     (symbol_clk),
    .rst            (rst),
    .load           (load),
    .advance        (advance),
    .switch_symbols (switch_symbols),
    .nslots         (nslots_for(mode)),
    .slot           (slot),
    .expect_sync    (expect_sync)
  );

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    advance    = 1'b0;
    route      = 3'b000;
    sync_err_d = 1'b0;
    if (mode == MODE_IDLE || mode > MODE_ROT3) begin
      state_d = StIdle;
    end else if (mode == MODE_PASS) begin
      state_d = StPass;
      if (state_q == StPass && in_valid) route = 3'b001;
    end else if (state_q == StIdle || state_q == StPass || mode != mode_q) begin
      // Entering or re-entering framed operation: the word on this cycle is dropped.
      state_d = StHunt;
    end else if (in_valid) begin
      unique case (state_q)
        StHunt: begin
          if (is_sync) begin
            load    = 1'b1;
            state_d = StLocked;
          end
        end
        StLocked: begin
          if (expect_sync) begin
            if (is_sync) begin
              load = 1'b1;
            end else begin
              sync_err_d = 1'b1;
              state_d    = StHunt;
            end
          end else begin
            advance = 1'b1;
            unique case (slot)
              2'd0:    route = 3'b001;
              2'd1:    route = 3'b010;
              default: route = 3'b100;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge symbol_clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mode_q      <= MODE_IDLE;
      ds1_data_q  <= '0;
      ds2_data_q  <= '0;
      ds3_data_q  <= '0;
      ds1_valid_q <= 1'b0;
      ds2_valid_q <= 1'b0;
      ds3_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode;
      ds1_valid_q <= route[0];
      ds2_valid_q <= route[1];
      ds3_valid_q <= route[2];
      if (route[0]) ds1_data_q <= in_data;
      if (route[1]) ds2_data_q <= in_data;
      if (route[2]) ds3_data_q <= in_data;
      sync_err_q <= sync_err_d;
      if (sync_err_d && err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
    end
  end

  assign ds1_data  = ds1_data_q;
  assign ds2_data  = ds2_data_q;
  assign ds3_data  = ds3_data_q;
  assign ds1_valid = ds1_valid_q;
  assign ds2_valid = ds2_valid_q;
  assign ds3_valid = ds3_valid_q;
  assign locked    = (state_q == StPass) || (state_q == StLocked);
  assign sync_err  = sync_err_q;
  assign err_count = err_count_q;

endmodule
